// File: rtl/qr_axis_pkg.sv
// Shared types and constants for the QR-CORDIC AXI-Stream matrix front end.
package qr_axis_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } qr_state_e;

    localparam int QR_TBITS = 64;
    localparam int QR_TBYTE = QR_TBITS / 8;
    localparam logic [QR_TBYTE-1:0] TKEEP_ALL = {QR_TBYTE{1'b1}};

    function automatic int frame_cnt_width();
        return 16;
    endfunction

    localparam int FCNT_W = frame_cnt_width();

endpackage

// File: rtl/qr_row_buffer.sv
// ROWS x TBITS matrix store: single-row write, zero-fill from an index, parallel
// load of a full result matrix, and a flat read bus in core packing order.
module qr_row_buffer #(
    parameter int TBITS = 64,
    parameter int ROWS  = 8,
    parameter int CNT_W = $clog2(ROWS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [CNT_W-1:0]      i_widx,
    input  logic [TBITS-1:0]      i_wdata,
    input  logic                  i_zero,
    input  logic [CNT_W-1:0]      i_zero_from,
    input  logic                  i_load,
    input  logic [ROWS*TBITS-1:0] i_load_data,
    output logic [ROWS*TBITS-1:0] o_flat
);

    logic [TBITS-1:0] r_rows [ROWS];

    // A write to row idx and zero-fill of rows idx+1.. never collide, so both can act in one cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < ROWS; r++) begin
                r_rows[r] <= '0;
            end
        end else if (i_load) begin
            for (int r = 0; r < ROWS; r++) begin
                r_rows[r] <= i_load_data[r*TBITS +: TBITS];
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (i_we && (i_widx == CNT_W'(r))) begin
                    r_rows[r] <= i_wdata;
                end else if (i_zero && (CNT_W'(r) >= i_zero_from)) begin
                    r_rows[r] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_flat
        assign o_flat[g*TBITS +: TBITS] = r_rows[g];
    end

endmodule

// File: rtl/qr_axis_matrix_io.sv
// AXI-Stream front end for the QR-CORDIC core: gathers one ROWS-word matrix frame,
// hands it to the core in parallel, waits for the result and streams it back out.
module qr_axis_matrix_io
    import qr_axis_pkg::*;
#(
    parameter int TBITS = QR_TBITS,
    parameter int TBYTE = TBITS / 8,
    parameter int ROWS  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  S_AXIS_MM2S_TVALID,
    output logic                  S_AXIS_MM2S_TREADY,
    input  logic [TBITS-1:0]      S_AXIS_MM2S_TDATA,
    input  logic [TBYTE-1:0]      S_AXIS_MM2S_TKEEP,
    input  logic                  S_AXIS_MM2S_TLAST,
    output logic                  M_AXIS_S2MM_TVALID,
    input  logic                  M_AXIS_S2MM_TREADY,
    output logic [TBITS-1:0]      M_AXIS_S2MM_TDATA,
    output logic [TBYTE-1:0]      M_AXIS_S2MM_TKEEP,
    output logic                  M_AXIS_S2MM_TLAST,
    output logic                  core_start,
    output logic [ROWS*TBITS-1:0] core_in_mat,
    input  logic                  core_done,
    input  logic [ROWS*TBITS-1:0] core_out_mat,
    output logic                  len_err,
    output logic                  keep_err,
    output logic [FCNT_W-1:0]     frame_cnt
);

    localparam int CNT_W = $clog2(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [TBYTE-1:0] KEEP_ALL =
        (TBYTE == QR_TBYTE) ? TBYTE'(TKEEP_ALL) : {TBYTE{1'b1}};

    qr_state_e          r_state;
    qr_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_idx;
    logic               r_s_tready;
    logic               r_m_tvalid;
    logic [TBITS-1:0]   r_m_tdata;
    logic [TBYTE-1:0]   r_m_tkeep;
    logic               r_m_tlast;
    logic               r_core_start;
    logic               r_len_err;
    logic               r_keep_err;
    logic [FCNT_W-1:0]  r_frame_cnt;

    logic               w_s_hs;
    logic               w_m_hs;
    logic               w_in_last_row;
    logic               w_close;
    logic               w_early;
    logic               w_capture;
    logic [CNT_W-1:0]   w_next_idx;
    logic [ROWS*TBITS-1:0] w_buf_flat;

    assign w_s_hs        = S_AXIS_MM2S_TVALID & r_s_tready;
    assign w_m_hs        = r_m_tvalid & M_AXIS_S2MM_TREADY;
    assign w_in_last_row = (r_idx == LAST_ROW);
    assign w_close       = w_s_hs & (S_AXIS_MM2S_TLAST | w_in_last_row);
    assign w_early       = w_s_hs & S_AXIS_MM2S_TLAST & ~w_in_last_row;
    assign w_capture     = (r_state == WAIT) & core_done;
    assign w_next_idx    = r_idx + CNT_W'(1);

    qr_row_buffer #(
        .TBITS (TBITS),
        .ROWS  (ROWS),
        .CNT_W (CNT_W)
    ) u_row_buffer (
        .i_clk       (aclk),
        .i_rst       (areset),
        .i_we        (w_s_hs),
        .i_widx      (r_idx),
        .i_wdata     (S_AXIS_MM2S_TDATA),
        .i_zero      (w_early),
        .i_zero_from (w_next_idx),
        .i_load      (w_capture),
        .i_load_data (core_out_mat),
        .o_flat      (w_buf_flat)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_close) w_state_nxt = START;
            START:   w_state_nxt = WAIT;
            WAIT:    if (core_done) w_state_nxt = DRAIN;
            DRAIN:   if (w_m_hs && r_m_tlast) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    // Output beat registers are preloaded one step ahead so TDATA/TLAST stay registered
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= LOAD;
            r_idx        <= '0;
            r_s_tready   <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tlast    <= 1'b0;
            r_core_start <= 1'b0;
            r_len_err    <= 1'b0;
            r_keep_err   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_s_tready   <= (w_state_nxt == LOAD);
            r_core_start <= w_close;

            if (w_s_hs) begin
                if (S_AXIS_MM2S_TKEEP != KEEP_ALL) r_keep_err <= 1'b1;
                if (w_close) begin
                    r_idx <= '0;
                    if (S_AXIS_MM2S_TLAST != w_in_last_row) r_len_err <= 1'b1;
                end else begin
                    r_idx <= w_next_idx;
                end
            end

            if (w_capture) begin
                r_idx      <= '0;
                r_m_tvalid <= 1'b1;
                r_m_tkeep  <= KEEP_ALL;
                r_m_tdata  <= core_out_mat[TBITS-1:0];
                r_m_tlast  <= 1'b0;
            end else if (w_m_hs) begin
                if (r_m_tlast) begin
                    r_idx       <= '0;
                    r_m_tvalid  <= 1'b0;
                    r_m_tkeep   <= '0;
                    r_m_tdata   <= '0;
                    r_m_tlast   <= 1'b0;
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                end else begin
                    r_idx     <= w_next_idx;
                    r_m_tdata <= w_buf_flat[w_next_idx*TBITS +: TBITS];
                    r_m_tlast <= (w_next_idx == LAST_ROW);
                end
            end
        end
    end

    assign S_AXIS_MM2S_TREADY = r_s_tready;
    assign M_AXIS_S2MM_TVALID = r_m_tvalid;
    assign M_AXIS_S2MM_TDATA  = r_m_tdata;
    assign M_AXIS_S2MM_TKEEP  = r_m_tkeep;
    assign M_AXIS_S2MM_TLAST  = r_m_tlast;
    assign core_start         = r_core_start;
    assign core_in_mat        = w_buf_flat;
    assign len_err            = r_len_err;
    assign keep_err           = r_keep_err;
    assign frame_cnt          = r_frame_cnt;

endmodule

// File: tb/tb_qr_axis_matrix_io.sv
// Self-checking bench for qr_axis_matrix_io: a frame model fills a scoreboard of expected
// core inputs and output beats; a core model returns each row XOR 0xFF after 5 cycles.
module tb_qr_axis_matrix_io;

    localparam int TBITS = 64;
    localparam int TBYTE = 8;
    localparam int ROWS  = 8;

    typedef struct packed {
        logic              last;
        logic [TBITS-1:0]  data;
    } beat_t;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic                  sValid;
    logic                  sReady;
    logic [TBITS-1:0]      sData;
    logic [TBYTE-1:0]      sKeep;
    logic                  sLast;
    logic                  mValid;
    logic                  mReady;
    logic [TBITS-1:0]      mData;
    logic [TBYTE-1:0]      mKeep;
    logic                  mLast;
    logic                  coreStart;
    logic [ROWS*TBITS-1:0] coreInMat;
    logic                  coreDone;
    logic [ROWS*TBITS-1:0] coreOutMat;
    logic                  lenErr;
    logic                  keepErr;
    logic [15:0]           frameCnt;

    int assertCount = 0;
    int failCount = 0;
    int framesExpected = 0;
    int coreStarts = 0;
    int outBeats = 0;
    bit randomReady = 1'b0;

    beat_t                 expOut[$];
    logic [ROWS*TBITS-1:0] expCore[$];
    logic [TBITS-1:0]      modelRows [ROWS];
    int                    modelIdx = 0;

    qr_axis_matrix_io #(
        .TBITS (TBITS),
        .TBYTE (TBYTE),
        .ROWS  (ROWS)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .S_AXIS_MM2S_TVALID (sValid),
        .S_AXIS_MM2S_TREADY (sReady),
        .S_AXIS_MM2S_TDATA  (sData),
        .S_AXIS_MM2S_TKEEP  (sKeep),
        .S_AXIS_MM2S_TLAST  (sLast),
        .M_AXIS_S2MM_TVALID (mValid),
        .M_AXIS_S2MM_TREADY (mReady),
        .M_AXIS_S2MM_TDATA  (mData),
        .M_AXIS_S2MM_TKEEP  (mKeep),
        .M_AXIS_S2MM_TLAST  (mLast),
        .core_start         (coreStart),
        .core_in_mat        (coreInMat),
        .core_done          (coreDone),
        .core_out_mat       (coreOutMat),
        .len_err            (lenErr),
        .keep_err           (keepErr),
        .frame_cnt          (frameCnt)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Frame model: rows accumulate until TLAST or row ROWS-1; short frames are zero-filled
    function automatic void modelPush(input logic [TBITS-1:0] data, input logic last);
        logic [ROWS*TBITS-1:0] flat;
        beat_t                 b;
        modelRows[modelIdx] = data;
        if (last || modelIdx == ROWS - 1) begin
            for (int r = modelIdx + 1; r < ROWS; r++) modelRows[r] = '0;
            for (int r = 0; r < ROWS; r++) begin
                flat[r*TBITS +: TBITS] = modelRows[r];
                b.last = (r == ROWS - 1);
                b.data = modelRows[r] ^ 64'hFF;
                expOut.push_back(b);
            end
            expCore.push_back(flat);
            framesExpected++;
            modelIdx = 0;
        end else begin
            modelIdx++;
        end
    endfunction

    // Drives one input beat from just after a rising edge and holds it until accepted
    task automatic applyStimulus(input logic [TBITS-1:0] data, input logic [TBYTE-1:0] keep, input logic last);
        bit accepted;
        accepted = 1'b0;
        sValid = 1'b1;
        sData  = data;
        sKeep  = keep;
        sLast  = last;
        for (int c = 0; c < 500 && !accepted; c++) begin
            @(negedge aclk);
            accepted = sReady;
            @(posedge aclk);
            #1;
        end
        sValid = 1'b0;
        sLast  = 1'b0;
        if (accepted) modelPush(data, last);
        else checkOutput("inputTimeout", 64'd0, 64'd1);
    endtask

    task automatic sendFrame(input logic [TBITS-1:0] base, input int beats, input int lastAt,
                             input int keepAt, input logic [TBYTE-1:0] oddKeep);
        for (int i = 0; i < beats; i++) begin
            applyStimulus(base + 64'(i), (i == keepAt) ? oddKeep : 8'hFF, (i == lastAt));
        end
    endtask

    task automatic waitIdle();
        int c;
        c = 0;
        while ((expOut.size() != 0 || expCore.size() != 0) && c < 3000) begin
            @(posedge aclk);
            c++;
        end
        if (c >= 3000) checkOutput("drainTimeout", 64'd0, 64'd1);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) begin
        #1;
        mReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Core model: checks the parallel input on core_start, answers 5 cycles later
    int                    countdown = 0;
    logic [ROWS*TBITS-1:0] latched;
    logic [ROWS*TBITS-1:0] expIn;
    always @(negedge aclk) begin
        if (areset) begin
            coreDone  = 1'b0;
            countdown = 0;
        end else begin
            coreDone = 1'b0;
            if (coreStart) begin
                coreStarts++;
                if (expCore.size() == 0) begin
                    checkOutput("coreStartUnexpected", 64'd1, 64'd0);
                end else begin
                    expIn = expCore.pop_front();
                    for (int r = 0; r < ROWS; r++) begin
                        checkOutput($sformatf("coreInRow%0d", r), coreInMat[r*TBITS +: TBITS], expIn[r*TBITS +: TBITS]);
                    end
                end
                latched   = coreInMat;
                countdown = 5;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    coreDone = 1'b1;
                    for (int r = 0; r < ROWS; r++) begin
                        coreOutMat[r*TBITS +: TBITS] = latched[r*TBITS +: TBITS] ^ 64'hFF;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks stall stability
    bit               stalled = 1'b0;
    logic [TBITS-1:0] heldData;
    logic             heldLast;
    beat_t            expBeat;
    always @(negedge aclk) begin
        if (areset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checkOutput("stallValid", 64'(mValid), 64'd1);
                checkOutput("stallData", mData, heldData);
                checkOutput("stallLast", 64'(mLast), 64'(heldLast));
            end
            stalled = 1'b0;
            if (mValid) begin
                checkOutput("inputBlocked", 64'(sReady), 64'd0);
                if (mReady) begin
                    outBeats++;
                    if (expOut.size() == 0) begin
                        checkOutput("outUnexpected", 64'd1, 64'd0);
                    end else begin
                        expBeat = expOut.pop_front();
                        checkOutput("outData", mData, expBeat.data);
                        checkOutput("outLast", 64'(mLast), 64'(expBeat.last));
                        checkOutput("outKeep", 64'(mKeep), 64'hFF);
                    end
                end else begin
                    stalled  = 1'b1;
                    heldData = mData;
                    heldLast = mLast;
                end
            end else begin
                checkOutput("keepIdle", 64'(mKeep), 64'd0);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "SReady"}, 64'(sReady), 64'd0);
        checkOutput({tag, "MValid"}, 64'(mValid), 64'd0);
        checkOutput({tag, "MData"}, mData, 64'd0);
        checkOutput({tag, "MKeep"}, 64'(mKeep), 64'd0);
        checkOutput({tag, "MLast"}, 64'(mLast), 64'd0);
        checkOutput({tag, "CoreStart"}, 64'(coreStart), 64'd0);
        checkOutput({tag, "LenErr"}, 64'(lenErr), 64'd0);
        checkOutput({tag, "KeepErr"}, 64'(keepErr), 64'd0);
        checkOutput({tag, "FrameCnt"}, 64'(frameCnt), 64'd0);
        for (int r = 0; r < ROWS; r++) begin
            checkOutput($sformatf("%sCoreIn%0d", tag, r), coreInMat[r*TBITS +: TBITS], 64'd0);
        end
    endtask

    initial begin
        int startsBefore;
        int beatTarget;
        int c;
        areset     = 1'b1;
        sValid     = 1'b0;
        sData      = '0;
        sKeep      = '0;
        sLast      = 1'b0;
        mReady     = 1'b1;
        coreDone   = 1'b0;
        coreOutMat = '0;

        repeat (3) @(posedge aclk);
        #1;
        checkAllZero("reset");
        #1;
        areset = 1'b0;
        #1;
        checkOutput("readyBeforeEdge", 64'(sReady), 64'd0);
        @(posedge aclk);
        #1;
        checkOutput("readyAfterRelease", 64'(sReady), 64'd1);

        $display("[TB] nominal frame");
        sendFrame(64'hA5A5_0000_0000_0000, 8, 7, -1, 8'hFF);
        waitIdle();
        checkOutput("nomFrameCnt", 64'(frameCnt), 64'd1);
        checkOutput("nomLenErr", 64'(lenErr), 64'd0);
        checkOutput("nomKeepErr", 64'(keepErr), 64'd0);
        checkOutput("nomReady", 64'(sReady), 64'd1);

        $display("[TB] output backpressure");
        randomReady = 1'b1;
        sendFrame(64'h1111_2222_3333_4400, 8, 7, -1, 8'hFF);
        sendFrame(64'hDEAD_BEEF_0000_1000, 8, 7, -1, 8'hFF);
        waitIdle();
        randomReady = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("bpFrameCnt", 64'(frameCnt), 64'(framesExpected));
        checkOutput("bpLenErr", 64'(lenErr), 64'd0);

        $display("[TB] partial TKEEP");
        sendFrame(64'h0F0F_0000_0000_0300, 8, 7, 3, 8'h0F);
        waitIdle();
        checkOutput("keepKeepErr", 64'(keepErr), 64'd1);
        checkOutput("keepLenErr", 64'(lenErr), 64'd0);

        $display("[TB] early TLAST");
        startsBefore = coreStarts;
        sendFrame(64'h5555_0000_0000_0500, 5, 4, -1, 8'hFF);
        waitIdle();
        checkOutput("earlyStarts", 64'(coreStarts - startsBefore), 64'd1);
        checkOutput("earlyLenErr", 64'(lenErr), 64'd1);

        $display("[TB] missing TLAST");
        sendFrame(64'h7777_0000_0000_0000, 10, -1, -1, 8'hFF);
        applyStimulus(64'h7777_0000_0000_00AA, 8'hFF, 1'b1);
        waitIdle();
        checkOutput("noLastFrameCnt", 64'(frameCnt), 64'(framesExpected));
        checkOutput("noLastLenErr", 64'(lenErr), 64'd1);

        $display("[TB] reset during drain");
        beatTarget = outBeats + 4;
        sendFrame(64'hCAFE_0000_0000_0000, 8, 7, -1, 8'hFF);
        c = 0;
        while (outBeats < beatTarget && c < 500) begin
            @(negedge aclk);
            c++;
        end
        if (c >= 500) checkOutput("drainReachTimeout", 64'd0, 64'd1);
        #1;
        areset = 1'b1;
        #1;
        checkAllZero("midReset");
        expOut.delete();
        expCore.delete();
        modelIdx = 0;
        framesExpected = 0;
        repeat (2) @(posedge aclk);
        #2;
        areset = 1'b0;
        #1;
        checkOutput("postResetReadyLow", 64'(sReady), 64'd0);
        @(posedge aclk);
        #1;
        checkOutput("postResetReady", 64'(sReady), 64'd1);
        checkOutput("postResetFrameCnt", 64'(frameCnt), 64'd0);
        sendFrame(64'hA5A5_0000_0000_0000, 8, 7, -1, 8'hFF);
        waitIdle();
        checkOutput("afterResetFrameCnt", 64'(frameCnt), 64'd1);
        checkOutput("afterResetLenErr", 64'(lenErr), 64'd0);
        checkOutput("afterResetKeepErr", 64'(keepErr), 64'd0);
        checkOutput("pendingOut", 64'(expOut.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
